// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// i2c_pkg : state encoding, ACK levels and R/W bit position for the I2C slave
// Revision : 1.0
// ============================================================================
package i2c_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_PTR       = 4'd3;
    localparam logic [3:0] ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int RW_BIT = 0;

endpackage
`default_nettype wire

// File: rtl/i2c_line_filter.sv
`default_nettype none
// ============================================================================
// i2c_line_filter : 2-flop synchroniser, FILTER-cycle debounce, edge pulses
// Revision : 1.0
// ============================================================================
module i2c_line_filter
    import i2c_pkg::*;
#(
    parameter int FILTER = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q, sync_d;
    logic [3:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       rise_q, rise_d;
    logic       fall_q, fall_d;

    // The bus idles high, so the filter starts from the released level.
    always_comb begin
        sync_d  = {sync_q[0], din};
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = 4'd0;
        end else if (cnt_q == 4'(FILTER - 1)) begin
            level_d = sync_q[1];
            cnt_d   = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
        rise_d = level_d & ~level_q;
        fall_d = ~level_d & level_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q  <= 2'b11;
            cnt_q   <= 4'd0;
            level_q <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule
`default_nettype wire

// File: rtl/i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// i2c_slave_regfile : I2C slave with auto-increment register file + local port
// Optional: I2C_SLAVE_GCALL_EN enables general-call writes from register 0.
// Revision : 1.0
// ============================================================================
module i2c_slave_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h42,
    parameter int         DEPTH    = 32,
    parameter int         FILTER   = 3,
    localparam int        AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          scl,
    inout  wire           sda,
    input  logic [AW-1:0] loc_addr,
    input  logic [7:0]    loc_wdata,
    input  logic          loc_we,
    output logic [7:0]    loc_rdata,
    output logic          loc_collision,
    output logic          bus_we,
    output logic [AW-1:0] bus_waddr,
    output logic [7:0]    bus_wdata,
    output logic          busy
);

`ifdef I2C_SLAVE_GCALL_EN
    localparam logic GCALL_EN = 1'b1;
`else
    localparam logic GCALL_EN = 1'b0;
`endif

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_filter #(.FILTER(FILTER)) u_scl_filter (
        .clk(clk), .reset(reset), .din(scl),
        .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.FILTER(FILTER)) u_sda_filter (
        .clk(clk), .reset(reset), .din(sda),
        .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
    );

    logic [7:0]    mem_q [DEPTH];
    logic [3:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [6:0]    shreg_q, shreg_d;
    logic [6:0]    tx_q, tx_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] gptr_q, gptr_d;
    logic          rw_q, rw_d;
    logic          gcall_q, gcall_d;
    logic          ack_seen_q, ack_seen_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_waddr_q, bus_waddr_d;
    logic [7:0]    bus_wdata_q, bus_wdata_d;
    logic [7:0]    loc_rdata_q, loc_rdata_d;
    logic          loc_collision_q, loc_collision_d;
    logic [7:0]    rx_byte;
    logic          start_det, stop_det;

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    assign rx_byte   = {shreg_q, sda_lvl};

    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        shreg_d         = shreg_q;
        tx_d            = tx_q;
        ptr_d           = ptr_q;
        gptr_d          = gptr_q;
        rw_d            = rw_q;
        gcall_d         = gcall_q;
        ack_seen_d      = ack_seen_q;
        sda_oe_d        = sda_oe_q;
        busy_d          = busy_q;
        bus_we_d        = 1'b0;
        bus_waddr_d     = bus_waddr_q;
        bus_wdata_d     = bus_wdata_q;
        loc_rdata_d     = mem_q[loc_addr];
        loc_collision_d = loc_we & bus_we_q;

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d    = ST_ADDR;
            bit_cnt_d  = 3'd0;
            sda_oe_d   = 1'b0;
            gcall_d    = 1'b0;
            ack_seen_d = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise) begin
                        shreg_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == ST_ADDR) begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_d = ST_ADDR_ACK;
                                    rw_d    = rx_byte[RW_BIT];
                                    busy_d  = 1'b1;
                                end else if (GCALL_EN && rx_byte == 8'h00) begin
                                    state_d = ST_ADDR_ACK;
                                    rw_d    = 1'b0;
                                    gcall_d = 1'b1;
                                    gptr_d  = '0;
                                    busy_d  = 1'b1;
                                end else begin
                                    state_d = ST_IDLE;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d   = rx_byte[AW-1:0];
                                state_d = ST_PTR_ACK;
                            end else begin
                                // General-call bursts use their own pointer so ptr survives them.
                                bus_we_d    = 1'b1;
                                bus_wdata_d = rx_byte;
                                state_d     = ST_WDATA_ACK;
                                if (gcall_q) begin
                                    bus_waddr_d = gptr_q;
                                    gptr_d      = gptr_q + AW'(1);
                                end else begin
                                    bus_waddr_d = ptr_q;
                                    ptr_d       = ptr_q + AW'(1);
                                end
                            end
                        end
                    end
                end
                ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
                    // First SCL fall drives the ACK, the second one ends the ACK bit.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = ~I2C_ACK;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            if (state_q == ST_ADDR_ACK && rw_q) begin
                                state_d  = ST_RDATA;
                                tx_d     = mem_q[ptr_q][6:0];
                                sda_oe_d = ~mem_q[ptr_q][7];
                            end else if (state_q == ST_ADDR_ACK && !gcall_q) begin
                                state_d = ST_PTR;
                            end else begin
                                state_d = ST_WDATA;
                            end
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_RDATA_ACK;
                            ptr_d   = ptr_q + AW'(1);
                        end
                    end else if (scl_fall) begin
                        sda_oe_d = ~tx_q[6];
                        tx_d     = {tx_q[5:0], 1'b0};
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_NACK) begin
                            state_d = ST_IDLE;
                        end else begin
                            ack_seen_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        if (ack_seen_q) begin
                            ack_seen_d = 1'b0;
                            state_d    = ST_RDATA;
                            bit_cnt_d  = 3'd0;
                            tx_d       = mem_q[ptr_q][6:0];
                            sda_oe_d   = ~mem_q[ptr_q][7];
                        end else begin
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= 3'd0;
            shreg_q         <= '0;
            tx_q            <= '0;
            ptr_q           <= '0;
            gptr_q          <= '0;
            rw_q            <= 1'b0;
            gcall_q         <= 1'b0;
            ack_seen_q      <= 1'b0;
            sda_oe_q        <= 1'b0;
            busy_q          <= 1'b0;
            bus_we_q        <= 1'b0;
            bus_waddr_q     <= '0;
            bus_wdata_q     <= '0;
            loc_rdata_q     <= '0;
            loc_collision_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            shreg_q         <= shreg_d;
            tx_q            <= tx_d;
            ptr_q           <= ptr_d;
            gptr_q          <= gptr_d;
            rw_q            <= rw_d;
            gcall_q         <= gcall_d;
            ack_seen_q      <= ack_seen_d;
            sda_oe_q        <= sda_oe_d;
            busy_q          <= busy_d;
            bus_we_q        <= bus_we_d;
            bus_waddr_q     <= bus_waddr_d;
            bus_wdata_q     <= bus_wdata_d;
            loc_rdata_q     <= loc_rdata_d;
            loc_collision_q <= loc_collision_d;
        end
    end

    // Bus write commits while bus_we is high and takes priority over the local port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (bus_we_q) begin
            mem_q[bus_waddr_q] <= bus_wdata_q;
        end else if (loc_we) begin
            mem_q[loc_addr] <= loc_wdata;
        end
    end

    assign sda           = sda_oe_q ? 1'b0 : 1'bz;
    assign loc_rdata     = loc_rdata_q;
    assign loc_collision = loc_collision_q;
    assign bus_we        = bus_we_q;
    assign bus_waddr     = bus_waddr_q;
    assign bus_wdata     = bus_wdata_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regfile.sv
`default_nettype none
// ============================================================================
// tb_i2c_slave_regfile : directed I2C master bench with hand-computed expectations
// Revision : 1.0
// ============================================================================
module tb_i2c_slave_regfile;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    wire        sda;
    logic [4:0] loc_addr = '0;
    logic [7:0] loc_wdata = '0;
    logic       loc_we = 1'b0;
    logic [7:0] loc_rdata;
    logic       loc_collision;
    logic       bus_we;
    logic [4:0] bus_waddr;
    logic [7:0] bus_wdata;
    logic       busy;

    pullup (sda);
    assign sda = m_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave_regfile #(.DEV_ADDR(7'h42), .DEPTH(32), .FILTER(3)) dut (
        .clk(clk), .reset(reset), .scl(scl), .sda(sda),
        .loc_addr(loc_addr), .loc_wdata(loc_wdata), .loc_we(loc_we),
        .loc_rdata(loc_rdata), .loc_collision(loc_collision),
        .bus_we(bus_we), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
        .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt = 0;
    int drove_cnt = 0;
    logic       mon_en = 1'b0;
    logic [4:0] last_addr = '0;
    logic [7:0] last_data = '0;

    always @(negedge clk) begin
        if (bus_we) begin
            we_cnt++;
            last_addr = bus_waddr;
            last_data = bus_wdata;
        end
        if (mon_en && !m_low && sda === 1'b0) drove_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_w(input logic b, input logic glitch);
        m_low = ~b;
        tick(Q);
        scl = 1'b1;
        if (glitch) begin
            tick(Q);
            scl = 1'b0;
            tick(1);
            scl = 1'b1;
            tick(Q);
        end else begin
            tick(2 * Q);
        end
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic bit_r(output logic b);
        m_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        b = sda;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic byte_w(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) bit_w(v[i], 1'b0);
        bit_r(ack);
    endtask

    task automatic byte_r(output logic [7:0] v, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bit_r(b);
            v[i] = b;
        end
        bit_w(ack, 1'b0);
    endtask

    task automatic start_c();
        m_low = 1'b0;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_low = 1'b1;
        tick(Q);
        scl = 1'b0;
        tick(Q);
    endtask

    task automatic stop_c();
        m_low = 1'b1;
        tick(Q);
        scl = 1'b1;
        tick(Q);
        m_low = 1'b0;
        tick(Q);
    endtask

    task automatic rd_loc(input logic [4:0] a, output logic [7:0] d);
        loc_addr = a;
        tick(2);
        d = loc_rdata;
    endtask

    initial begin
        logic       ack;
        logic       any_nack;
        logic [7:0] d;
        int         we0;
        int         dr0;
        logic       coll1, coll2, seen;

        tick(5);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_bus_we", bus_we, 0);
        check_eq("rst_collision", loc_collision, 0);
        check_eq("rst_loc_rdata", loc_rdata, 0);
        check_eq("rst_bus_waddr", bus_waddr, 0);
        check_eq("rst_bus_wdata", bus_wdata, 0);
        check_eq("rst_sda", sda, 1);
        reset = 1'b1;
        tick(10);

        // Write burst: pointer 5, data AA BB
        we0 = we_cnt;
        start_c();
        byte_w(8'h84, ack); check_eq("wr_addr_ack", ack, 0);
        check_eq("wr_busy", busy, 1);
        byte_w(8'h05, ack); check_eq("wr_ptr_ack", ack, 0);
        byte_w(8'hAA, ack); check_eq("wr_d0_ack", ack, 0);
        check_eq("wr_d0_waddr", last_addr, 5);
        check_eq("wr_d0_wdata", last_data, 8'hAA);
        byte_w(8'hBB, ack); check_eq("wr_d1_ack", ack, 0);
        check_eq("wr_d1_waddr", last_addr, 6);
        check_eq("wr_d1_wdata", last_data, 8'hBB);
        stop_c();
        tick(10);
        check_eq("wr_we_count", we_cnt - we0, 2);
        check_eq("wr_busy_end", busy, 0);
        rd_loc(5'd5, d); check_eq("wr_mem5", d, 8'hAA);
        rd_loc(5'd6, d); check_eq("wr_mem6", d, 8'hBB);

        // Pointer wrap at DEPTH-1
        any_nack = 1'b0;
        start_c();
        byte_w(8'h84, ack); any_nack |= ack;
        byte_w(8'h1F, ack); any_nack |= ack;
        byte_w(8'h11, ack); any_nack |= ack;
        byte_w(8'h22, ack); any_nack |= ack;
        stop_c();
        check_eq("wrap_acks", any_nack, 0);
        rd_loc(5'd31, d); check_eq("wrap_mem31", d, 8'h11);
        rd_loc(5'd0, d);  check_eq("wrap_mem0", d, 8'h22);

        // Read with repeated START
        start_c();
        byte_w(8'h84, ack); check_eq("rd_addr_ack", ack, 0);
        byte_w(8'h05, ack); check_eq("rd_ptr_ack", ack, 0);
        start_c();
        byte_w(8'h85, ack); check_eq("rd_raddr_ack", ack, 0);
        byte_r(d, 1'b0); check_eq("rd_byte0", d, 8'hAA);
        byte_r(d, 1'b1); check_eq("rd_byte1", d, 8'hBB);
        check_eq("rd_sda_released", sda, 1);
        stop_c();

        // Address mismatch: NACK and no drive at all
        dr0 = drove_cnt;
        mon_en = 1'b1;
        start_c();
        byte_w(8'h86, ack);
        mon_en = 1'b0;
        check_eq("mis_nack", ack, 1);
        check_eq("mis_no_drive", drove_cnt - dr0, 0);
        check_eq("mis_busy", busy, 0);
        stop_c();

        // One-cycle SCL glitch inside the address byte
        start_c();
        for (int i = 7; i >= 0; i--) bit_w(d[0] ^ d[0] ^ (8'h84 >> i) & 1'b1, i == 3);
        bit_r(ack); check_eq("glitch_addr_ack", ack, 0);
        byte_w(8'h09, ack); any_nack = ack;
        byte_w(8'h5A, ack); any_nack |= ack;
        stop_c();
        check_eq("glitch_acks", any_nack, 0);
        rd_loc(5'd9, d); check_eq("glitch_mem9", d, 8'h5A);

        // Local write colliding with a bus write to the same register
        coll1 = 1'b0; coll2 = 1'b1; seen = 1'b0;
        fork
            begin
                start_c();
                byte_w(8'h84, ack);
                byte_w(8'h07, ack);
                byte_w(8'h3C, ack);
                stop_c();
            end
            begin
                for (int i = 0; i < 3000 && !seen; i++) begin
                    @(negedge clk);
                    if (bus_we) seen = 1'b1;
                end
                if (seen) begin
                    loc_addr = 5'd7; loc_wdata = 8'h55; loc_we = 1'b1;
                    @(negedge clk);
                    coll1 = loc_collision;
                    loc_we = 1'b0;
                    @(negedge clk);
                    coll2 = loc_collision;
                end
            end
        join
        check_eq("coll_bus_we_seen", seen, 1);
        check_eq("coll_pulse", coll1, 1);
        check_eq("coll_pulse_end", coll2, 0);
        rd_loc(5'd7, d); check_eq("coll_mem7", d, 8'h3C);

        // Uncontended local write
        loc_addr = 5'd3; loc_wdata = 8'h77; loc_we = 1'b1;
        tick(1);
        loc_we = 1'b0;
        tick(1);
        check_eq("loc_wr_visible", loc_rdata, 8'h77);
        check_eq("loc_wr_no_coll", loc_collision, 0);

        // Reset after 4 data bits
        we0 = we_cnt;
        start_c();
        byte_w(8'h84, ack);
        byte_w(8'h02, ack);
        for (int i = 0; i < 4; i++) bit_w(1'b1, 1'b0);
        check_eq("mid_busy_before", busy, 1);
        reset = 1'b0;
        tick(2);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_sda", sda, 1);
        reset = 1'b1;
        tick(2);
        rd_loc(5'd5, d); check_eq("mid_rst_mem5", d, 0);
        rd_loc(5'd7, d); check_eq("mid_rst_mem7", d, 0);
        for (int i = 0; i < 4; i++) bit_w(1'b0, 1'b0);
        bit_r(ack); check_eq("mid_no_ack", ack, 1);
        stop_c();
        check_eq("mid_no_we", we_cnt - we0, 0);
        start_c();
        byte_w(8'h84, ack); any_nack = ack;
        byte_w(8'h02, ack); any_nack |= ack;
        byte_w(8'h66, ack); any_nack |= ack;
        stop_c();
        check_eq("post_rst_acks", any_nack, 0);
        rd_loc(5'd2, d); check_eq("post_rst_mem2", d, 8'h66);

        // General call
        start_c();
`ifdef I2C_SLAVE_GCALL_EN
        byte_w(8'h00, ack); check_eq("gcall_ack", ack, 0);
        byte_w(8'h99, ack); check_eq("gcall_data_ack", ack, 0);
        stop_c();
        rd_loc(5'd0, d); check_eq("gcall_mem0", d, 8'h99);
`else
        byte_w(8'h00, ack); check_eq("gcall_nack", ack, 1);
        stop_c();
        rd_loc(5'd0, d); check_eq("gcall_mem0", d, 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
